// File: rtl/gray_ptr_monitor_if.sv
// Pointer-crossing handshake bundle: Gray pointer in, binary decode and step delta out.
// master = producer/consumer side, slave = the monitor.
interface gray_ptr_monitor_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic [WIDTH:0]   delta;
  logic             delta_valid;
  logic             delta_ready;
  logic             err;
  logic             err_clr;

  modport master (output gray_in, delta_ready, err_clr,
                  input  bin_out, bin_valid, delta, delta_valid, err);
  modport slave  (input  gray_in, delta_ready, err_clr,
                  output bin_out, bin_valid, delta, delta_valid, err);
endinterface

// File: rtl/gray_ptr_monitor.sv
// Receive side of a Gray pointer crossing: synchronize, decode, validate single-bit
// transitions and accumulate net steps as a saturating signed delta.
module gray_ptr_monitor #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gray_ptr_monitor_if.slave   bus
);
  localparam int HW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic signed [WIDTH+1:0] LIM = (WIDTH+2)'((2 ** WIDTH) - 1);

  typedef enum logic [1:0] {PRIME, RUN, RESYNC} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] s;
  logic [WIDTH-1:0]  g_sync, g_prev, bin_now, bin_prev, bin_inc, bin_q;
  logic [HW-1:0]     hd;
  logic [CW-1:0]     cnt;
  logic              prime_done, bin_ld, bin_vq, ill, sat, err_q, dv_q;
  logic signed [WIDTH+1:0] step, sum;
  logic signed [WIDTH:0]   acc, acc_nx;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    g2b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) g2b[i] = g2b[i+1] ^ g[i];
  endfunction

  assign g_sync     = s[SYNC_STAGES-1];
  assign bin_now    = g2b(g_sync);
  assign bin_prev   = g2b(g_prev);
  assign bin_inc    = bin_prev + WIDTH'(1);
  assign prime_done = (state == PRIME) && (cnt == CW'(SYNC_STAGES));
  assign bin_ld     = (state != PRIME) || prime_done;

  always_comb begin
    hd = '0;
    for (int i = 0; i < WIDTH; i++) hd = hd + HW'(g_sync[i] ^ g_prev[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s      <= '0;
      g_prev <= '0;
    end else begin
      s      <= {s[SYNC_STAGES-2:0], bus.gray_in};
      g_prev <= g_sync;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PRIME;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      PRIME:   if (prime_done) state_nx = RUN;
      RUN:     if (hd > HW'(1)) state_nx = RESYNC;
      RESYNC:  state_nx = RUN;
      default: state_nx = PRIME;
    endcase
  end

  // FSM: outputs -- steps and transition checks only happen in RUN
  always_comb begin
    step = '0;
    ill  = 1'b0;
    if (state == RUN) begin
      if (hd == HW'(1))     step = (bin_now == bin_inc) ? (WIDTH+2)'(1) : -(WIDTH+2)'(1);
      else if (hd > HW'(1)) ill  = 1'b1;
    end
  end

  // Accept reloads with the same-edge step so no step is dropped.
  always_comb begin
    sum    = {acc[WIDTH], acc} + step;
    acc_nx = acc;
    sat    = 1'b0;
    if (dv_q && bus.delta_ready)   acc_nx = step[WIDTH:0];
    else if (sum > LIM || sum < -LIM) sat = 1'b1;
    else                           acc_nx = sum[WIDTH:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bin_q  <= '0;
      bin_vq <= 1'b0;
      acc    <= '0;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == PRIME && !prime_done) cnt <= cnt + CW'(1);
      if (bin_ld) bin_q <= bin_now;
      if (prime_done) bin_vq <= 1'b1;
      acc  <= acc_nx;
      dv_q <= (acc_nx != '0);
      if (ill || sat)       err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.bin_out     = bin_q;
  assign bus.bin_valid   = bin_vq;
  assign bus.delta       = acc;
  assign bus.delta_valid = dv_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_gray_ptr_monitor.sv
// Directed bench for gray_ptr_monitor at WIDTH=4, SYNC_STAGES=2.
module tb_gray_ptr_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cur;

  always #5 clk = ~clk;

  gray_ptr_monitor_if #(.WIDTH(4)) bus();
  gray_ptr_monitor #(.WIDTH(4), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int dlt();
    return int'($signed(bus.delta));
  endfunction

  task automatic accept_pulse();
    bus.delta_ready = 1'b1; tick(1); bus.delta_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
  endtask

  initial begin
    bus.gray_in = 4'b0110; bus.delta_ready = 1'b0; bus.err_clr = 1'b0;
    #2;
    chk("rst_bin_out", bus.bin_out, 0);
    chk("rst_bin_valid", bus.bin_valid, 0);
    chk("rst_delta_valid", bus.delta_valid, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk); rst = 1'b0;
    tick(1); chk("prime_e1_valid", bus.bin_valid, 0);
    tick(1); chk("prime_e2_valid", bus.bin_valid, 0);
    tick(1);
    chk("prime_e3_valid", bus.bin_valid, 1);
    chk("prime_bin_out", bus.bin_out, 4);
    chk("prime_delta_valid", bus.delta_valid, 0);
    chk("prime_err", bus.err, 0);

    // two up-steps 4->5->6
    bus.gray_in = 4'b0111; tick(4);
    chk("up1_delta", dlt(), 1);
    bus.gray_in = 4'b0101; tick(4);
    chk("up2_delta", dlt(), 2);
    chk("up2_bin", bus.bin_out, 6);
    accept_pulse();
    chk("acc_delta", dlt(), 0);
    chk("acc_valid", bus.delta_valid, 0);

    // illegal jump 6 -> 15
    bus.gray_in = 4'b1000; tick(3);
    chk("jump_err", bus.err, 1);
    chk("jump_delta", dlt(), 0);
    chk("jump_bin", bus.bin_out, 15);
    clr_pulse();
    chk("clr1_err", bus.err, 0);

    // wrap 15 -> 0 is +1, then 0 -> 15 is -1
    bus.gray_in = 4'b0000; tick(3);
    chk("wrap_up_delta", dlt(), 1);
    chk("wrap_up_bin", bus.bin_out, 0);
    bus.gray_in = 4'b1000; tick(3);
    chk("wrap_dn_delta", dlt(), 0);
    chk("wrap_dn_valid", bus.delta_valid, 0);
    chk("wrap_dn_bin", bus.bin_out, 15);
    bus.gray_in = 4'b0000; tick(3);
    chk("rewrap_delta", dlt(), 1);

    // illegal 0000 -> 0011, then legal 0011 -> 0010
    bus.gray_in = 4'b0011; tick(3);
    chk("ill_err", bus.err, 1);
    chk("ill_delta", dlt(), 1);
    bus.gray_in = 4'b0010; tick(3);
    chk("post_resync_delta", dlt(), 2);
    chk("post_resync_bin", bus.bin_out, 3);
    clr_pulse();
    chk("clr2_err", bus.err, 0);

    // err_clr on the same edge as a new illegal jump: set wins
    bus.gray_in = 4'b0100; tick(2);
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
    chk("setwins_err", bus.err, 1);
    chk("setwins_delta", dlt(), 2);
    chk("setwins_bin", bus.bin_out, 7);
    clr_pulse();
    chk("clr3_err", bus.err, 0);
    accept_pulse();
    chk("acc2_delta", dlt(), 0);

    // saturation at +15
    cur = 7;
    for (int i = 1; i <= 15; i++) begin
      bus.gray_in = b2g(cur + i); tick(2);
    end
    tick(1);
    chk("sat15_delta", dlt(), 15);
    chk("sat15_err", bus.err, 0);
    bus.gray_in = b2g(cur + 16); tick(3);
    chk("sat16_delta", dlt(), 15);
    chk("sat16_err", bus.err, 1);
    bus.gray_in = b2g(cur + 17); tick(3);
    chk("sat17_delta", dlt(), 15);
    // accept coinciding with a new step
    bus.gray_in = b2g(cur + 18); tick(2);
    bus.delta_ready = 1'b1; tick(1); bus.delta_ready = 1'b0;
    chk("acc_step_delta", dlt(), 1);
    chk("acc_step_valid", bus.delta_valid, 1);
    cur = (cur + 18) % 16;
    chk("acc_step_bin", bus.bin_out, cur);
    clr_pulse();

    // build +3 then async reset mid-cycle
    cur++; bus.gray_in = b2g(cur); tick(3);
    cur++; bus.gray_in = b2g(cur); tick(3);
    chk("build3_delta", dlt(), 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_bin_out", bus.bin_out, 0);
    chk("arst_bin_valid", bus.bin_valid, 0);
    chk("arst_delta", dlt(), 0);
    chk("arst_delta_valid", bus.delta_valid, 0);
    chk("arst_err", bus.err, 0);
    @(negedge clk); rst = 1'b0;
    tick(2); chk("rearm_e2_valid", bus.bin_valid, 0);
    tick(1);
    chk("rearm_e3_valid", bus.bin_valid, 1);
    chk("rearm_bin", bus.bin_out, cur);
    chk("rearm_delta", dlt(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
